// File: rtl/rotary_bargraph_ctrl.sv
// rotary_bargraph_ctrl
// Turns quadrature edge pulses into a detent-quantised, saturating level,
// renders it as a bar or dot pattern and streams each new pattern MSB-first
// to a 74HC595-style serial-in/parallel-out LED register.
module rotary_bargraph_ctrl #(
    parameter int LEDS    = 8,   // segments / serial frame length (2..32)
    parameter int DETENT  = 4,   // Shift pulses per detent (1..8)
    parameter int SER_DIV = 4    // Clk cycles per serial clock half-period (1..16)
) (
    input  logic                       Clk,
    input  logic                       Reset_N,
    input  logic                       Shift,
    input  logic                       Dir,
    input  logic                       Mode_Tgl,
    output logic [$clog2(LEDS+1)-1:0]  Level,
    output logic                       Mode,
    output logic [LEDS-1:0]            Bar,
    output logic                       Ser_Data,
    output logic                       Ser_Clk,
    output logic                       Ser_Latch,
    output logic                       Busy
);

    localparam int LW = $clog2(LEDS + 1);
    localparam int AW = $clog2(DETENT + 1) + 1;
    localparam int CW = (SER_DIV > 1) ? $clog2(SER_DIV) : 1;
    localparam int IW = $clog2(LEDS);

    localparam logic signed [AW-1:0] ACC_TOP = AW'(DETENT - 1);
    localparam logic signed [AW-1:0] ACC_ONE = AW'(1);
    localparam logic [LW-1:0]        LVL_MAX = LW'(LEDS);
    localparam logic [LW-1:0]        LVL_ONE = LW'(1);
    localparam logic [CW-1:0]        DIV_END = CW'(SER_DIV - 1);
    localparam logic [CW-1:0]        DIV_ONE = CW'(1);
    localparam logic [IW-1:0]        IDX_TOP = IW'(LEDS - 1);
    localparam logic [IW-1:0]        IDX_ONE = IW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLK_LO,
        S_CLK_HI,
        S_LATCH
    } state_t;

    logic signed [AW-1:0] acc;
    logic                 step_up;
    logic                 step_dn;
    logic [LEDS-1:0]      pattern;
    logic [LEDS-1:0]      bar_d;
    logic                 bar_chg;
    logic                 pending;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [IW-1:0]        idx, idx_nxt;
    logic [LEDS-1:0]      snap;
    logic                 load;

    // A step fires on the pulse that would take the accumulator to +/-DETENT.
    assign step_up = Shift &&  Dir && (acc == ACC_TOP);
    assign step_dn = Shift && !Dir && (acc == -ACC_TOP);

    // Detent accumulator: counts edges, clears whenever a detent completes.
    always_ff @(posedge Clk or negedge Reset_N) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!Reset_N)
            acc <= '0;
        else if (step_up || step_dn)
            acc <= '0;
        else if (Shift)
            acc <= Dir ? acc + ACC_ONE : acc - ACC_ONE;
    end

    // Saturating level and display mode.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            Level <= '0;
            Mode  <= 1'b0;
        end else begin
            if (step_up && Level != LVL_MAX)
                Level <= Level + LVL_ONE;
            else if (step_dn && Level != '0)
                Level <= Level - LVL_ONE;
            if (Mode_Tgl)
                Mode <= !Mode;
        end
    end

    // Bar/dot rendering of the registered level and mode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        pattern = '0;
        for (int i = 0; i < LEDS; i++) begin
            if (Mode)
                pattern[i] = (int'(Level) == i + 1);
            else
                pattern[i] = (i < int'(Level));
        end
    end

    // Registered pattern, its one-cycle-old copy and the pending-frame flag.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            Bar     <= '0;
            bar_d   <= '0;
            pending <= 1'b1;   // guarantees a cleared frame after reset
        end else begin
            Bar   <= pattern;
            bar_d <= Bar;
            if (bar_chg)
                pending <= 1'b1;   // a new change outranks the LOAD clear
            else if (load)
                pending <= 1'b0;
        end
    end

    assign bar_chg = (Bar != bar_d);

    // Serial FSM state, timing counter, bit index and frame snapshot.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            snap  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            if (load)
                snap <= Bar;
        end
    end

    // Serial FSM next state and decoded serial outputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        load      = 1'b0;
        Busy      = (state != S_IDLE);
        Ser_Clk   = 1'b0;
        Ser_Latch = 1'b0;
        Ser_Data  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (pending)
                    state_nxt = S_LOAD;
            end
            S_LOAD: begin
                load      = 1'b1;
                idx_nxt   = IDX_TOP;
                cnt_nxt   = '0;
                state_nxt = S_CLK_LO;
            end
            S_CLK_LO: begin
                Ser_Data = snap[idx];
                if (cnt == DIV_END) begin
                    cnt_nxt   = '0;
                    state_nxt = S_CLK_HI;
                end else begin
                    cnt_nxt = cnt + DIV_ONE;
                end
            end
            S_CLK_HI: begin
                Ser_Data = snap[idx];
                Ser_Clk  = 1'b1;
                if (cnt == DIV_END) begin
                    cnt_nxt = '0;
                    if (idx == '0) begin
                        state_nxt = S_LATCH;
                    end else begin
                        idx_nxt   = idx - IDX_ONE;
                        state_nxt = S_CLK_LO;
                    end
                end else begin
                    cnt_nxt = cnt + DIV_ONE;
                end
            end
            S_LATCH: begin
                Ser_Latch = 1'b1;
                if (cnt == DIV_END) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + DIV_ONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/rotary_bargraph_ctrl.md
# rotary_bargraph_ctrl

Controller between the quadrature decoder and the LED bargraph. It converts the decoder's per-edge `Shift`/`Dir` pulses into a detent-quantised, saturating level, and renders that level as a bar or dot pattern. It streams each new pattern to an external serial-in/parallel-out LED shift register (74HC595 style). It owns all sequencing of the display path; the decoder only supplies edge events.

## Interface
- `LEDS`, 8: number of bargraph segments and serial frame length in bits (2..32).
- `DETENT`, 4: decoder `Shift` pulses per mechanical detent (1..8).
- `SER_DIV`, 4: `Clk` cycles per serial clock half-period (1..16).

- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset_N`  in  1  asynchronous, active-low reset.
- `Shift`  in  1  one-cycle pulse per quadrature edge, from the decoder.
- `Dir`  in  1  direction qualifier, valid when `Shift`=1; 1 = step up, 0 = step down.
- `Mode_Tgl`  in  1  one-cycle pulse; toggles the display mode.
- `Level`  out  clog2(LEDS+1)  current level, 0..LEDS.
- `Mode`  out  1  display mode: 0 = BAR, 1 = DOT.
- `Bar`  out  LEDS  registered display pattern.
- `Ser_Data`  out  1  serial data, MSB (`Bar[LEDS-1]`) first.
- `Ser_Clk`  out  1  serial shift clock; the receiver samples on its rising edge.
- `Ser_Latch`  out  1  storage-register latch pulse.
- `Busy`  out  1  high while a serial frame is in progress.

## Operation
- **Detent accumulator.** Signed, range −(DETENT−1)..+(DETENT−1).
  - `Shift` with `Dir`=1 increments it; reaching +DETENT clears it to 0 and requests a level step up.
  - `Shift` with `Dir`=0 decrements it; reaching −DETENT clears it to 0 and requests a level step down.
  - Reversals cancel naturally.
  - With DETENT=1, every `Shift` pulse is a step.
- **Level.** Steps ±1 and saturates at 0 and LEDS.
  - A step beyond a limit is discarded and `Level` is unchanged.
  - The accumulator still clears in that case.
- **Mode.** Toggles on each `Mode_Tgl` pulse.
- **Pattern.**
  - BAR: bits [Level−1:0] = 1, all others 0.
  - DOT: only bit Level−1 = 1.
  - Level=0 gives all zeros in both modes.
- **Pending flag.** Set whenever the registered `Bar` changes value. Also set by reset.
- **Serial FSM states:** IDLE, LOAD, CLK_LO, CLK_HI, LATCH.
  - IDLE: if pending is set → LOAD.
  - LOAD (1 cycle): snapshot `Bar` into the shift register, clear pending, set bit index to LEDS−1, go to CLK_LO.
  - CLK_LO (SER_DIV cycles): `Ser_Clk`=0, `Ser_Data` = current snapshot bit, then go to CLK_HI.
  - CLK_HI (SER_DIV cycles): `Ser_Clk`=1 with `Ser_Data` held. Then go to CLK_LO with the next bit, or to LATCH after bit 0.
  - LATCH (SER_DIV cycles): `Ser_Clk`=0, `Ser_Latch`=1, then go to IDLE.
- **Busy.** Busy=1 in every state except IDLE.
- **Pattern changes during a frame.** The snapshot is not disturbed. Pending is set, so exactly one further frame carries the latest `Bar`; intermediate values may be skipped.
- **Simultaneous events.**
  - `Shift` and `Mode_Tgl` in the same cycle: both take effect, and the new pattern uses the new level and the new mode.
  - A pending set in the same cycle as LOAD clears it: set wins.

## Timing
- **Reset values (asynchronous on `Reset_N`=0):**
  - Outputs: `Level`=0, `Mode`=0, `Bar`=0, `Ser_Data`=0, `Ser_Clk`=0, `Ser_Latch`=0, `Busy`=0.
  - Internal: accumulator=0, FSM=IDLE, pending=1.
- **After reset release.** The first clock moves the FSM from IDLE to LOAD, so a cleared frame is always sent after reset.
- **Reset mid-frame.** All outputs return to reset values at once; the frame is abandoned and restarts from LOAD after release.
- **Latency.**
  - Step-causing `Shift` sampled at edge n → `Level` updates at edge n.
  - → `Bar` updates at edge n+1 → pending set at n+2 → `Busy`=1 (LOAD) at n+3.
- **Frame length.** 1 + 2·SER_DIV·LEDS + SER_DIV cycles of `Busy`=1. With defaults: 1 + 64 + 4 = 69.
- **Data/clock relationship.** `Ser_Data` is stable for SER_DIV cycles before and throughout each `Ser_Clk` high.
- **Back-to-back frames.** At least one IDLE cycle (`Busy`=0) separates consecutive frames.
- **Input pulse rate.** The block accepts `Shift` every cycle; no event is lost while `Busy`=1.

## Test plan
- **Reset frame.** Release reset with no activity → exactly one frame of 8 zero bits, `Ser_Latch` high for 4 cycles, `Busy` high for 69 cycles, then `Busy`=0 and the outputs stay idle.
- **Quantisation.**
  - Four `Shift`/`Dir`=1 pulses → `Level`=1, `Bar`=8'h01, frame shifts 0000_0001.
  - Three up pulses then three down pulses → `Level` unchanged and no frame.
- **Saturation.**
  - 40 up detents → `Level`=8, `Bar`=8'hFF, further up pulses cause no change.
  - 40 down detents → `Level`=0, `Bar`=8'h00.
- **Mode.** At Level=5, pulse `Mode_Tgl` → `Bar` goes from 8'h1F to 8'h10, `Mode`=1. `Mode_Tgl` together with an up-step → `Bar`=8'h20.
- **Coalescing.** Three level changes (1→2→3→4) while `Busy`=1 → the current frame completes unchanged, followed by exactly one frame carrying 8'h0F (BAR mode).
- **Reset mid-frame.** Assert `Reset_N`=0 at bit 3 of a frame → all outputs are immediately zero; after release, a full all-zero frame is sent.
